systolic_layer_sequencer: RTL and testbench
===========================================

# systolic_layer_sequencer

Sequences a list of convolution passes through the systolic wrapper without host involvement per pass. Holds a small descriptor table (image width, height, kernel size per pass), validates each descriptor, and drives the wrapper's configuration and start. It tracks the wrapper's level `done`, runs a per-pass watchdog, and reports progress, completion and errors to the top-level controller. Sits between the host/CSR block and `systolic_wrapper`.

## Interface
- `MAX_LAYERS`, default 4: descriptor table depth.
- `PTR_WIDTH`, default 32: width of the image width/height fields; matches the wrapper.
- `MAX_IMG_W`, default 1920: largest legal image width (line buffer limit).
- `MAX_K`, default 7: largest legal kernel size.
- `TIMEOUT_CYC`, default 2^20: maximum cycles allowed in WAIT per pass.
- `LW`, derived, $clog2(MAX_LAYERS+1): width of the layer count and index ports.

- `clk_i`, input, 1: clock.
- `rst_async_n_i`, input, 1: reset, asynchronous, active-low.
- `desc_wr_en_i`, input, 1: write one descriptor entry.
- `desc_wr_idx_i`, input, LW: entry index; writes with index ≥ MAX_LAYERS are dropped.
- `desc_img_w_i` / `desc_img_h_i`, input, PTR_WIDTH each: image width and height for the entry.
- `desc_kernel_r_i`, input, 4: kernel size for the entry.
- `num_layers_i`, input, LW: number of passes to run; sampled only on run.
- `run_i`, input, 1: start the sequence; honoured only in IDLE.
- `abort_i`, input, 1: abandon the sequence.
- `sa_cfg_img_w_o` / `sa_cfg_img_h_o`, output, PTR_WIDTH each: image size to the wrapper.
- `sa_cfg_kernel_r_o`, output, 4: kernel size to the wrapper.
- `sa_start_o`, output, 1: single-cycle start pulse to the wrapper.
- `sa_done_i`, input, 1: wrapper `done` (level; cleared by the wrapper on start).
- `busy_o`, output, 1: sequence in progress.
- `layer_done_o`, output, 1: one-cycle pulse per completed pass.
- `cur_layer_o`, output, LW: index of the active pass.
- `done_o`, output, 1: one-cycle pulse when all passes complete.
- `err_o`, output, 1: sticky error flag.
- `err_code_o`, output, 2: 1 = bad descriptor, 2 = timeout.

## Operation
- States: IDLE, CHECK, START, SETTLE, WAIT, NEXT, FIN, ERR.
- **IDLE**
  - `run_i`=1 clears `err_o`/`err_code_o` and latches `num_layers_i` into `n_reg`.
  - `n_reg` clamped to MAX_LAYERS if larger.
  - Next state: FIN if `n_reg`=0, else CHECK with idx=0.
- **CHECK**
  - Copy descriptor[idx] into the `sa_cfg_*` registers.
  - Descriptor is valid iff 1 ≤ k ≤ MAX_K, k ≤ w, k ≤ h, and w ≤ MAX_IMG_W.
  - Invalid → ERR with code 1, and no start is issued. Valid → START.
- **START**: `sa_start_o`=1 for exactly this cycle; clear watchdog. Next state SETTLE.
- **SETTLE**: one cycle, so a stale `sa_done_i` from the previous pass is never sampled. Next state WAIT.
- **WAIT**
  - `sa_done_i`=1 → NEXT.
  - Watchdog counter reaching TIMEOUT_CYC-1 → ERR with code 2.
- **NEXT**: `layer_done_o`=1. If idx+1 = `n_reg` → FIN; else idx increments and state goes to CHECK.
- **FIN**: `done_o`=1. Next state IDLE.
- **ERR**: `err_o`=1, `busy_o`=0. Next state IDLE next cycle. `err_o`/`err_code_o` hold until the next accepted `run_i` or reset.
- `busy_o` = state ∉ {IDLE, ERR}.
- `cur_layer_o` = idx; it holds its last value in IDLE.
- `sa_cfg_*` are registered and stay stable from CHECK through WAIT; they keep their last values after the sequence ends.
- Descriptor writes:
  - Accepted in any state when `busy_o`=0.
  - Ignored while `busy_o`=1, so the active table is immutable.
- **Abort**: `abort_i` in any state other than IDLE/ERR → IDLE next cycle.
  - No `done_o`, no `layer_done_o`, no error set.
  - The START pulse of that cycle is suppressed.
  - Abort has priority over every other transition.
  - The wrapper is not reset; a new run re-issues start, which restarts the wrapper.
- Simultaneous `sa_done_i` and watchdog expiry in WAIT: done wins.
- Writing a descriptor in the same cycle `run_i` is accepted: the write completes and CHECK reads the new value.

## Timing
- Reset:
  - state IDLE, idx 0.
  - All outputs 0, including `sa_cfg_*`.
  - Descriptor table all zeros, i.e. invalid kernel.
- `run_i` in cycle n → CHECK in n+1, `sa_start_o` in n+2, SETTLE in n+3, WAIT from n+4.
- `sa_done_i` first sampled high in WAIT cycle m → `layer_done_o` in m+1.
  - Then either CHECK in m+2 (start of next pass in m+3), or `done_o` in m+2 and IDLE in m+3.
- `num_layers_i`=0: `done_o` in n+1, `busy_o` high only in cycle n+1.
- Error: ERR state one cycle after the detecting CHECK/WAIT cycle; `busy_o` falls the same cycle.
- Watchdog counts WAIT cycles only. With TIMEOUT_CYC=T, ERR is entered T+1 cycles after the first WAIT cycle when done never rises.

## Test plan
- **Single pass**: descriptor 0 = (28, 28, 5), num=1, run at cycle 10. Expect start at 12, `cfg` = 28/28/5 from 11. Model done at 40 → `layer_done_o` at 41, `done_o` at 42, busy low at 43.
- **Multi-pass**: entries (28,28,5), (14,14,5), (10,10,3), num=3. Expect three start pulses, `cur_layer_o` 0→1→2, three `layer_done_o`, exactly one `done_o`. A done level held through START of the next pass is never double-counted.
- **Bad descriptor**: entry 1 = (4,28,5), num=2. Expect pass 0 completes, no second start, `err_o`=1 with code 1, `busy_o`=0, `done_o` never asserted.
- **Timeout**: TIMEOUT_CYC=16, done never asserted. Expect ERR with code 2 exactly 17 cycles after WAIT entry. A subsequent run clears `err_o`.
- **Abort and write lockout**: abort during WAIT → IDLE next cycle, no pulses. A descriptor write while busy leaves the table unchanged (verified on a rerun).
- **Reset mid-WAIT**: all outputs 0 immediately, table zeroed. Run with num=1 and no rewrite → code-1 error.

Source files
------------

// File: rtl/systolic_layer_sequencer_if.sv
// Command/status bundle between the host/CSR side, the layer sequencer and the
// systolic wrapper control lines. master = host + wrapper side, slave = sequencer.
interface systolic_layer_sequencer_if #(
    parameter int MAX_LAYERS = 4,
    parameter int PTR_WIDTH  = 32
);
    localparam int LW = $clog2(MAX_LAYERS + 1);

    logic                 desc_wr_en_i;
    logic [LW-1:0]        desc_wr_idx_i;
    logic [PTR_WIDTH-1:0] desc_img_w_i;
    logic [PTR_WIDTH-1:0] desc_img_h_i;
    logic [3:0]           desc_kernel_r_i;
    logic [LW-1:0]        num_layers_i;
    logic                 run_i;
    logic                 abort_i;
    logic [PTR_WIDTH-1:0] sa_cfg_img_w_o;
    logic [PTR_WIDTH-1:0] sa_cfg_img_h_o;
    logic [3:0]           sa_cfg_kernel_r_o;
    logic                 sa_start_o;
    logic                 sa_done_i;
    logic                 busy_o;
    logic                 layer_done_o;
    logic [LW-1:0]        cur_layer_o;
    logic                 done_o;
    logic                 err_o;
    logic [1:0]           err_code_o;

    modport master (
        output desc_wr_en_i, desc_wr_idx_i, desc_img_w_i, desc_img_h_i, desc_kernel_r_i,
        output num_layers_i, run_i, abort_i, sa_done_i,
        input  sa_cfg_img_w_o, sa_cfg_img_h_o, sa_cfg_kernel_r_o, sa_start_o,
        input  busy_o, layer_done_o, cur_layer_o, done_o, err_o, err_code_o
    );

    modport slave (
        input  desc_wr_en_i, desc_wr_idx_i, desc_img_w_i, desc_img_h_i, desc_kernel_r_i,
        input  num_layers_i, run_i, abort_i, sa_done_i,
        output sa_cfg_img_w_o, sa_cfg_img_h_o, sa_cfg_kernel_r_o, sa_start_o,
        output busy_o, layer_done_o, cur_layer_o, done_o, err_o, err_code_o
    );
endinterface

// File: rtl/systolic_layer_sequencer.sv
// Walks a small descriptor table of convolution passes, validating each entry,
// configuring and starting the systolic wrapper, and guarding every pass with a
// watchdog. Progress, completion and error status go back to the controller.
module systolic_layer_sequencer #(
    parameter int MAX_LAYERS  = 4,
    parameter int PTR_WIDTH   = 32,
    parameter int MAX_IMG_W   = 1920,
    parameter int MAX_K       = 7,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input logic                   clk_i,
    input logic                   rst_async_n_i,
    systolic_layer_sequencer_if.slave bus
);
    localparam int LW   = $clog2(MAX_LAYERS + 1);
    localparam int IW   = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_START, S_SETTLE, S_WAIT, S_NEXT, S_FIN, S_ERR
    } state_t;

    state_t               r_state;
    logic [LW-1:0]        r_n;
    logic [LW-1:0]        r_idx;
    logic [PTR_WIDTH-1:0] r_cfg_w;
    logic [PTR_WIDTH-1:0] r_cfg_h;
    logic [3:0]           r_cfg_k;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_layer_done;
    logic                 r_done;
    logic                 r_err;
    logic [1:0]           r_err_code;
    logic [WD_W-1:0]      r_wdog;
    logic                 r_wd_exp;

    logic [PTR_WIDTH-1:0] r_tab_w [MAX_LAYERS];
    logic [PTR_WIDTH-1:0] r_tab_h [MAX_LAYERS];
    logic [3:0]           r_tab_k [MAX_LAYERS];

    logic                 w_wr_ok;
    logic [IW-1:0]        w_wr_slot;
    logic                 w_run_hit;
    logic [LW-1:0]        w_num_cl;
    logic [LW-1:0]        w_idx_nxt;
    logic [IW-1:0]        w_nxt_slot;
    logic [PTR_WIDTH-1:0] w_k_ext;
    logic                 w_desc_ok;
    logic                 w_kill;

    // Table is frozen while a sequence runs; out-of-range indices are dropped.
    assign w_wr_ok    = bus.desc_wr_en_i && !r_busy && (bus.desc_wr_idx_i < LW'(MAX_LAYERS));
    assign w_wr_slot  = bus.desc_wr_idx_i[IW-1:0];
    // A write to entry 0 in the run cycle is forwarded so CHECK sees the new value.
    assign w_run_hit  = w_wr_ok && (bus.desc_wr_idx_i == '0);
    assign w_num_cl   = (bus.num_layers_i > LW'(MAX_LAYERS)) ? LW'(MAX_LAYERS) : bus.num_layers_i;
    assign w_idx_nxt  = r_idx + LW'(1);
    assign w_nxt_slot = w_idx_nxt[IW-1:0];

    assign w_k_ext   = PTR_WIDTH'(r_cfg_k);
    assign w_desc_ok = (r_cfg_k != 4'd0) && (r_cfg_k <= 4'(MAX_K)) &&
                       (w_k_ext <= r_cfg_w) && (w_k_ext <= r_cfg_h) &&
                       (r_cfg_w <= PTR_WIDTH'(MAX_IMG_W));

    // Abort outside IDLE/ERR also cancels any pulse due in the same cycle.
    assign w_kill = bus.abort_i && (r_state != S_IDLE) && (r_state != S_ERR);

    assign bus.sa_cfg_img_w_o    = r_cfg_w;
    assign bus.sa_cfg_img_h_o    = r_cfg_h;
    assign bus.sa_cfg_kernel_r_o = r_cfg_k;
    assign bus.sa_start_o        = r_start && !w_kill;
    assign bus.busy_o            = r_busy;
    assign bus.layer_done_o      = r_layer_done && !w_kill;
    assign bus.cur_layer_o       = r_idx;
    assign bus.done_o            = r_done && !w_kill;
    assign bus.err_o             = r_err;
    assign bus.err_code_o        = r_err_code;

    // Descriptor table storage, cleared to all-zero (invalid) entries on reset.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                r_tab_w[i] <= '0;
                r_tab_h[i] <= '0;
                r_tab_k[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_tab_w[w_wr_slot] <= bus.desc_img_w_i;
            r_tab_h[w_wr_slot] <= bus.desc_img_h_i;
            r_tab_k[w_wr_slot] <= bus.desc_kernel_r_i;
        end
    end

    // Pass sequencer FSM with registered status, config and watchdog.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_idx        <= '0;
            r_cfg_w      <= '0;
            r_cfg_h      <= '0;
            r_cfg_k      <= '0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
            r_wdog       <= '0;
            r_wd_exp     <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_layer_done <= 1'b0;
            r_done       <= 1'b0;
            if (w_kill) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.run_i) begin
                            r_err      <= 1'b0;
                            r_err_code <= 2'd0;
                            r_n        <= w_num_cl;
                            r_idx      <= '0;
                            r_busy     <= 1'b1;
                            if (w_num_cl == '0) begin
                                r_state <= S_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_CHECK;
                                r_cfg_w <= w_run_hit ? bus.desc_img_w_i    : r_tab_w[0];
                                r_cfg_h <= w_run_hit ? bus.desc_img_h_i    : r_tab_h[0];
                                r_cfg_k <= w_run_hit ? bus.desc_kernel_r_i : r_tab_k[0];
                            end
                        end
                    end
                    S_CHECK: begin
                        if (w_desc_ok) begin
                            r_state <= S_START;
                            r_start <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= 2'd1;
                            r_busy     <= 1'b0;
                        end
                    end
                    S_START: begin
                        r_wdog   <= '0;
                        r_wd_exp <= 1'b0;
                        r_state  <= S_SETTLE;
                    end
                    S_SETTLE: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (bus.sa_done_i) begin
                            r_state      <= S_NEXT;
                            r_layer_done <= 1'b1;
                        end else if (r_wd_exp) begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                            r_busy     <= 1'b0;
                        end else begin
                            // Registered expiry compare: flag rises the cycle after the last allowed count.
                            r_wdog   <= r_wdog + WD_W'(1);
                            r_wd_exp <= (r_wdog == WD_LAST);
                        end
                    end
                    S_NEXT: begin
                        if (w_idx_nxt == r_n) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_CHECK;
                            r_idx   <= w_idx_nxt;
                            r_cfg_w <= r_tab_w[w_nxt_slot];
                            r_cfg_h <= r_tab_h[w_nxt_slot];
                            r_cfg_k <= r_tab_k[w_nxt_slot];
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    S_ERR:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_systolic_layer_sequencer.sv
// Directed bench for the layer sequencer: single/multi pass, bad descriptor,
// zero passes, abort with write lockout, watchdog timeout and mid-run reset.
module tb_systolic_layer_sequencer;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n0;
    int   n_pass;
    int   n_tot;
    int   c_start;
    int   c_ld;
    int   c_done;
    int   s0;
    int   ld0;
    int   d0;

    systolic_layer_sequencer_if #(.MAX_LAYERS(4), .PTR_WIDTH(32)) bus ();
    systolic_layer_sequencer_if #(.MAX_LAYERS(4), .PTR_WIDTH(32)) bus_t ();

    systolic_layer_sequencer #(.MAX_LAYERS(4), .PTR_WIDTH(32)) u_dut (
        .clk_i(clk), .rst_async_n_i(rst_n), .bus(bus)
    );

    systolic_layer_sequencer #(.MAX_LAYERS(4), .PTR_WIDTH(32), .TIMEOUT_CYC(16)) u_dut_t (
        .clk_i(clk), .rst_async_n_i(rst_n), .bus(bus_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sa_start_o === 1'b1)   c_start++;
        if (bus.layer_done_o === 1'b1) c_ld++;
        if (bus.done_o === 1'b1)       c_done++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic upto(input int c);
        while (cyc < n0 + c) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input int idx, input int w, input int h, input int k);
        bus.desc_wr_en_i    = 1'b1;
        bus.desc_wr_idx_i   = idx[2:0];
        bus.desc_img_w_i    = w;
        bus.desc_img_h_i    = h;
        bus.desc_kernel_r_i = k[3:0];
        tick();
        bus.desc_wr_en_i    = 1'b0;
    endtask

    task automatic snap();
        n0  = cyc;
        s0  = c_start;
        ld0 = c_ld;
        d0  = c_done;
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_tot = 0; c_start = 0; c_ld = 0; c_done = 0;
        rst_n = 1'b0;
        bus.desc_wr_en_i = 0; bus.desc_wr_idx_i = 0; bus.desc_img_w_i = 0; bus.desc_img_h_i = 0;
        bus.desc_kernel_r_i = 0; bus.num_layers_i = 0; bus.run_i = 0; bus.abort_i = 0; bus.sa_done_i = 0;
        bus_t.desc_wr_en_i = 0; bus_t.desc_wr_idx_i = 0; bus_t.desc_img_w_i = 0; bus_t.desc_img_h_i = 0;
        bus_t.desc_kernel_r_i = 0; bus_t.num_layers_i = 0; bus_t.run_i = 0; bus_t.abort_i = 0; bus_t.sa_done_i = 0;
        tick(); tick();
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_cfg_w", bus.sa_cfg_img_w_o, 0);
        chk("rst_cfg_k", bus.sa_cfg_kernel_r_o, 0);
        chk("rst_start", bus.sa_start_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_cur", bus.cur_layer_o, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Single pass
        wr(0, 28, 28, 5);
        bus.num_layers_i = 1; bus.run_i = 1; snap();
        tick(); bus.run_i = 0;
        chk("sp_busy", bus.busy_o, 1);
        chk("sp_cfg_w", bus.sa_cfg_img_w_o, 28);
        chk("sp_cfg_h", bus.sa_cfg_img_h_o, 28);
        chk("sp_cfg_k", bus.sa_cfg_kernel_r_o, 5);
        chk("sp_start_early", bus.sa_start_o, 0);
        tick(); chk("sp_start", bus.sa_start_o, 1);
        tick(); chk("sp_start_once", bus.sa_start_o, 0);
        upto(30); bus.sa_done_i = 1;
        tick(); chk("sp_layer_done", bus.layer_done_o, 1); chk("sp_cur", bus.cur_layer_o, 0);
        tick(); chk("sp_done", bus.done_o, 1); chk("sp_busy_fin", bus.busy_o, 1);
        tick(); chk("sp_idle_busy", bus.busy_o, 0); chk("sp_idle_done", bus.done_o, 0);
        bus.sa_done_i = 0;
        chk("sp_n_start", c_start - s0, 1);
        chk("sp_n_ld", c_ld - ld0, 1);
        chk("sp_n_done", c_done - d0, 1);

        // Multi pass, done level held through the next START/SETTLE
        wr(1, 14, 14, 5);
        wr(2, 10, 10, 3);
        bus.num_layers_i = 3; bus.run_i = 1; snap();
        for (int c = 1; c <= 23; c++) begin
            tick();
            if (c == 1) bus.run_i = 0;
            case (c)
                8:  begin chk("mp_cur1", bus.cur_layer_o, 1); chk("mp_cfg_w1", bus.sa_cfg_img_w_o, 14); end
                9:  chk("mp_start1", bus.sa_start_o, 1);
                15: begin chk("mp_cur2", bus.cur_layer_o, 2); chk("mp_cfg_w2", bus.sa_cfg_img_w_o, 10);
                          chk("mp_cfg_k2", bus.sa_cfg_kernel_r_o, 3); end
                22: chk("mp_done", bus.done_o, 1);
                23: chk("mp_idle", bus.busy_o, 0);
                default: ;
            endcase
            bus.sa_done_i = ((c >= 6 && c <= 10) || (c >= 13 && c <= 17) || c >= 20);
        end
        bus.sa_done_i = 0;
        chk("mp_n_start", c_start - s0, 3);
        chk("mp_n_ld", c_ld - ld0, 3);
        chk("mp_n_done", c_done - d0, 1);

        // Bad descriptor on pass 1 (width smaller than kernel)
        wr(1, 4, 28, 5);
        bus.num_layers_i = 2; bus.run_i = 1; snap();
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) bus.run_i = 0;
            case (c)
                8:  chk("bd_cfg_w", bus.sa_cfg_img_w_o, 4);
                9:  begin chk("bd_err", bus.err_o, 1); chk("bd_code", bus.err_code_o, 1);
                          chk("bd_busy", bus.busy_o, 0); end
                10: chk("bd_err_hold", bus.err_o, 1);
                default: ;
            endcase
            bus.sa_done_i = (c >= 6);
        end
        bus.sa_done_i = 0;
        chk("bd_n_start", c_start - s0, 1);
        chk("bd_n_ld", c_ld - ld0, 1);
        chk("bd_n_done", c_done - d0, 0);

        // Zero passes; run also clears the sticky error
        bus.num_layers_i = 0; bus.run_i = 1; snap();
        tick(); bus.run_i = 0;
        chk("z_done", bus.done_o, 1); chk("z_busy", bus.busy_o, 1); chk("z_err_clr", bus.err_o, 0);
        tick();
        chk("z_busy_off", bus.busy_o, 0); chk("z_done_off", bus.done_o, 0);

        // Abort in WAIT with a locked-out write, rerun, then run+write and abort in CHECK
        bus.num_layers_i = 1; bus.run_i = 1; snap();
        for (int c = 1; c <= 17; c++) begin
            tick();
            case (c)
                1:  bus.run_i = 0;
                5:  begin bus.abort_i = 1; bus.desc_wr_en_i = 1; bus.desc_wr_idx_i = 0;
                          bus.desc_img_w_i = 9; bus.desc_img_h_i = 9; bus.desc_kernel_r_i = 3; end
                6:  begin bus.abort_i = 0; bus.desc_wr_en_i = 0;
                          chk("ab_busy", bus.busy_o, 0); chk("ab_ld", bus.layer_done_o, 0);
                          chk("ab_done", bus.done_o, 0); chk("ab_err", bus.err_o, 0); end
                7:  bus.run_i = 1;
                8:  begin bus.run_i = 0; chk("lk_cfg_w", bus.sa_cfg_img_w_o, 28);
                          chk("lk_cfg_k", bus.sa_cfg_kernel_r_o, 5); end
                12: bus.sa_done_i = 1;
                13: chk("lk_ld", bus.layer_done_o, 1);
                14: chk("lk_done", bus.done_o, 1);
                15: begin bus.sa_done_i = 0; bus.run_i = 1; bus.desc_wr_en_i = 1; bus.desc_wr_idx_i = 0;
                          bus.desc_img_w_i = 20; bus.desc_img_h_i = 20; bus.desc_kernel_r_i = 3; end
                16: begin bus.run_i = 0; bus.desc_wr_en_i = 0;
                          chk("fw_cfg_w", bus.sa_cfg_img_w_o, 20); chk("fw_cfg_k", bus.sa_cfg_kernel_r_o, 3);
                          bus.abort_i = 1; end
                17: begin bus.abort_i = 0; chk("ac_busy", bus.busy_o, 0); end
                default: ;
            endcase
        end
        tick();
        chk("ac_no_start", bus.sa_start_o, 0);
        chk("ab_n_start", c_start - s0, 2);
        chk("ab_n_ld", c_ld - ld0, 1);
        chk("ab_n_done", c_done - d0, 1);

        // Watchdog timeout on the short-timeout instance
        bus_t.desc_wr_en_i = 1; bus_t.desc_wr_idx_i = 0; bus_t.desc_img_w_i = 28;
        bus_t.desc_img_h_i = 28; bus_t.desc_kernel_r_i = 5;
        bus_t.num_layers_i = 1; bus_t.run_i = 1; snap();
        for (int c = 1; c <= 23; c++) begin
            tick();
            case (c)
                1:  begin bus_t.desc_wr_en_i = 0; bus_t.run_i = 0;
                          chk("to_cfg_w", bus_t.sa_cfg_img_w_o, 28); end
                20: begin chk("to_err_early", bus_t.err_o, 0); chk("to_busy_early", bus_t.busy_o, 1); end
                21: begin chk("to_err", bus_t.err_o, 1); chk("to_code", bus_t.err_code_o, 2);
                          chk("to_busy", bus_t.busy_o, 0); end
                22: bus_t.run_i = 1;
                23: begin bus_t.run_i = 0; chk("to_err_clr", bus_t.err_o, 0);
                          chk("to_code_clr", bus_t.err_code_o, 0); chk("to_rerun_busy", bus_t.busy_o, 1);
                          bus_t.abort_i = 1; end
                default: ;
            endcase
        end
        tick(); bus_t.abort_i = 0;
        chk("to_abort_idle", bus_t.busy_o, 0);

        // Asynchronous reset in WAIT, then run on the zeroed table
        bus.num_layers_i = 1; bus.run_i = 1; snap();
        tick(); bus.run_i = 0;
        upto(5);
        chk("rs_pre_busy", bus.busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", bus.busy_o, 0);
        chk("rs_cfg_w", bus.sa_cfg_img_w_o, 0);
        chk("rs_cfg_k", bus.sa_cfg_kernel_r_o, 0);
        chk("rs_start", bus.sa_start_o, 0);
        tick(); rst_n = 1'b1;
        tick();
        wr(4, 7, 7, 3);
        bus.num_layers_i = 1; bus.run_i = 1;
        tick(); bus.run_i = 0;
        chk("rs_tab_k", bus.sa_cfg_kernel_r_o, 0);
        chk("rs_tab_w", bus.sa_cfg_img_w_o, 0);
        tick();
        chk("rs_err", bus.err_o, 1);
        chk("rs_code", bus.err_code_o, 1);
        chk("rs_err_busy", bus.busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
